// File: rtl/fifo_programable.sv
// fifo_programable: synchronous FIFO with programmable almost-full/almost-empty thresholds and occupancy count
module fifo_programable #(
  parameter int tamano_datos    = 10,
  parameter int tamano_direcion = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic                       read_enable,
  input  logic [tamano_datos-1:0]    data_in,
  input  logic [tamano_direcion:0]   umbral_alto,
  input  logic [tamano_direcion:0]   umbral_bajo,
  output logic [tamano_datos-1:0]    data_out,
  output logic                       valid_out,
  output logic [tamano_direcion-1:0] wr_ptr,
  output logic [tamano_direcion-1:0] rd_ptr,
  output logic [tamano_direcion:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       error
);
  localparam int DEPTH = 2 ** tamano_direcion;
  localparam logic [tamano_direcion:0]   depth_c = DEPTH[tamano_direcion:0];
  localparam logic [tamano_direcion:0]   cnt_one = 1;
  localparam logic [tamano_direcion-1:0] ptr_one = 1;
  logic [tamano_datos-1:0]    mem_q [DEPTH];
  logic [tamano_datos-1:0]    data_out_q;
  logic                       valid_q, full_q, empty_q, af_q, ae_q, error_q;
  logic [tamano_direcion-1:0] wr_ptr_q, rd_ptr_q;
  logic [tamano_direcion:0]   count_q, count_d;
  logic                       wr_ok, rd_ok, ovf, unf;
  // a write into a full FIFO is accepted only when a read frees a slot in the same edge
  assign wr_ok = write_enable & (~full_q | read_enable);
  assign rd_ok = read_enable & ~empty_q;
  assign ovf   = write_enable & full_q & ~read_enable;
  assign unf   = read_enable & empty_q;
  always_comb begin
    count_d = (wr_ok && !rd_ok) ? count_q + cnt_one :
              (rd_ok && !wr_ok) ? count_q - cnt_one : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ptr_one;
      if (rd_ok) begin
        rd_ptr_q   <= rd_ptr_q + ptr_one;
        data_out_q <= mem_q[rd_ptr_q];
      end
      valid_q <= rd_ok;
      count_q <= count_d;
      full_q  <= count_d == depth_c;
      empty_q <= count_d == '0;
      af_q    <= count_d >= umbral_alto;
      ae_q    <= count_d <= umbral_bajo;
      error_q <= error_q | ovf | unf;
    end
  end
  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign error        = error_q;
endmodule

// File: tb/tb_fifo_programable.sv
// tb_fifo_programable: directed checks of fifo_programable against hand-computed values
module tb_fifo_programable;
  logic       clk = 1'b0;
  logic       reset, write_enable, read_enable;
  logic [9:0] data_in, data_out;
  logic [3:0] umbral_alto, umbral_bajo, count;
  logic [2:0] wr_ptr, rd_ptr;
  logic       valid_out, full, empty, almost_full, almost_empty, error;
  int n_chk = 0;
  int n_err = 0;
  fifo_programable dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
    .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0; write_enable = 1'b0; read_enable = 1'b0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_err", error, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_wptr", wr_ptr, 0);
    chk("rst_rptr", rd_ptr, 0);
    reset = 1'b1;
    // fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      write_enable = 1'b1; data_in = 10'(i);
      step();
      chk("fill_count", count, i);
      chk("fill_af", almost_full, int'(i >= 6));
      chk("fill_full", full, int'(i == 8));
      chk("fill_ae", almost_empty, int'(i <= 2));
      chk("fill_empty", empty, 0);
    end
    write_enable = 1'b0;
    chk("fill_wptr", wr_ptr, 0);
    chk("fill_err", error, 0);
    // drain
    for (int i = 1; i <= 8; i++) begin
      read_enable = 1'b1;
      step();
      chk("drain_dout", data_out, i);
      chk("drain_valid", valid_out, 1);
      chk("drain_count", count, 8 - i);
      chk("drain_empty", empty, int'(i == 8));
      chk("drain_ae", almost_empty, int'(8 - i <= 2));
    end
    read_enable = 1'b0;
    step();
    chk("hold_valid", valid_out, 0);
    chk("hold_dout", data_out, 8);
    // refill with 10..17, then 4 simultaneous read+write on full
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1; data_in = 10'(10 + i);
      step();
    end
    chk("refill_full", full, 1);
    for (int k = 0; k < 4; k++) begin
      write_enable = 1'b1; read_enable = 1'b1; data_in = 10'(10'h3FF - k);
      step();
      chk("rw_count", count, 8);
      chk("rw_full", full, 1);
      chk("rw_dout", data_out, 10 + k);
      chk("rw_valid", valid_out, 1);
      chk("rw_err", error, 0);
    end
    // overflow: word dropped, pointer held
    read_enable = 1'b0; write_enable = 1'b1; data_in = 10'h0AA;
    step();
    write_enable = 1'b0;
    chk("ovf_err", error, 1);
    chk("ovf_count", count, 8);
    chk("ovf_wptr", wr_ptr, 4);
    begin
      int exp_q[8] = '{14, 15, 16, 17, 'h3FF, 'h3FE, 'h3FD, 'h3FC};
      for (int i = 0; i < 8; i++) begin
        read_enable = 1'b1;
        step();
        chk("ovf_drain", data_out, exp_q[i]);
      end
    end
    read_enable = 1'b0;
    chk("ovf_drain_empty", empty, 1);
    // underflow after reset
    do_reset();
    chk("rst2_err", error, 0);
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    chk("unf_err", error, 1);
    chk("unf_valid", valid_out, 0);
    chk("unf_rptr", rd_ptr, 0);
    chk("unf_count", count, 0);
    // empty + read + write: no bypass
    do_reset();
    write_enable = 1'b1; read_enable = 1'b1; data_in = 10'h155;
    step();
    write_enable = 1'b0;
    chk("byp_count", count, 1);
    chk("byp_err", error, 1);
    chk("byp_valid", valid_out, 0);
    chk("byp_empty", empty, 0);
    step();
    read_enable = 1'b0;
    chk("byp_dout", data_out, 'h155);
    chk("byp_valid2", valid_out, 1);
    chk("byp_count2", count, 0);
    // five words, threshold change, then mid-stream reset
    for (int i = 0; i < 5; i++) begin
      write_enable = 1'b1; data_in = 10'(i + 20);
      step();
    end
    write_enable = 1'b0;
    chk("mid_count", count, 5);
    chk("mid_af", almost_full, 0);
    umbral_alto = 4'd5;
    step();
    chk("thr_af", almost_full, 1);
    umbral_alto = 4'd6;
    reset = 1'b0; write_enable = 1'b1; read_enable = 1'b1;
    step();
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_err", error, 0);
    chk("mrst_wptr", wr_ptr, 0);
    chk("mrst_rptr", rd_ptr, 0);
    chk("mrst_valid", valid_out, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
